// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus bundle: halfword memory request/ack port plus the
// instruction valid/ready handshake towards decode.
interface rv32i_fetch_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ILEN     = 32,
  parameter int unsigned BUS_BITS = 16
) ();

  logic [XLEN-1:0]     mem_addr_o;
  logic                mem_req_o;
  logic                mem_ack_i;
  logic [BUS_BITS-1:0] mem_data_i;

  logic [ILEN-1:0]     inst_o;
  logic [XLEN-1:0]     inst_pc_o;
  logic                inst_valid_o;
  logic                inst_ready_i;

  // Fetch stage side
  modport master (
    output mem_addr_o, mem_req_o,
    input  mem_ack_i, mem_data_i,
    output inst_o, inst_pc_o, inst_valid_o,
    input  inst_ready_i
  );

  // Memory / decode side
  modport slave (
    input  mem_addr_o, mem_req_o,
    output mem_ack_i, mem_data_i,
    input  inst_o, inst_pc_o, inst_valid_o,
    output inst_ready_i
  );

endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, fetches two halfwords per instruction,
// hands the assembled word to decode, and handles redirects and fetch faults.
module rv32i_fetch #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     ILEN         = 32,
  parameter int unsigned     BUS_BITS     = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  rv32i_fetch_if.master       bus,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_addr_i,
  output logic                fault_o,
  output logic [1:0]          fault_cause_o
);

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_LO    = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ENCODING = 2'b10;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [1:0]      cause_q, cause_d;
  logic            drop_q, drop_d;
  logic            req_active;
  logic            take_ack;

  // drop_q masks the request for the single cycle after a redirect, so the
  // memory sees the old request cancelled before the new address appears.
  assign req_active = ((state_q == ST_LO) || (state_q == ST_HI)) && !drop_q;
  assign take_ack   = req_active && bus.mem_ack_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    cause_d   = cause_q;
    drop_d    = 1'b0;

    if (redirect_i && (state_q != ST_START)) begin
      pc_d    = redirect_addr_i;
      valid_d = 1'b0;
      drop_d  = 1'b1;
      if (redirect_addr_i[1:0] != 2'b00) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
        cause_d = CAUSE_MISALIGN;
      end else begin
        state_d = ST_LO;
        fault_d = 1'b0;
        cause_d = CAUSE_NONE;
      end
    end else begin
      case (state_q)
        ST_START: state_d = ST_LO;
        ST_LO: begin
          if (take_ack) begin
            if (bus.mem_data_i[1:0] != 2'b11) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
              cause_d = CAUSE_ENCODING;
            end else begin
              inst_d[BUS_BITS-1:0] = bus.mem_data_i;
              state_d              = ST_HI;
            end
          end
        end
        ST_HI: begin
          if (take_ack) begin
            inst_d[ILEN-1:BUS_BITS] = bus.mem_data_i;
            inst_pc_d               = pc_q;
            valid_d                 = 1'b1;
            state_d                 = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (valid_q && bus.inst_ready_i) begin
            valid_d = 1'b0;
            pc_d    = pc_q + XLEN'(4);
            state_d = ST_LO;
          end
        end
        ST_FAULT: valid_d = 1'b0;
        default:  state_d = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_START;
      pc_q      <= RESET_VECTOR;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.mem_req_o    = req_active;
  assign bus.mem_addr_o   = (state_q == ST_HI) ? (pc_q + XLEN'(2)) : pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = inst_pc_q;
  assign bus.inst_valid_o = valid_q;
  assign fault_o          = fault_q;
  assign fault_cause_o    = cause_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch with hand-computed expectations.
module tb_rv32i_fetch;

  logic        clk_i;
  logic        reset_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        fault_o;
  logic [1:0]  fault_cause_o;

  int unsigned n_cmp;
  int unsigned n_err;

  rv32i_fetch_if #(.XLEN(32), .ILEN(32), .BUS_BITS(16)) bus ();

  rv32i_fetch #(
    .XLEN(32), .ILEN(32), .BUS_BITS(16), .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bus(bus),
    .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .fault_o(fault_o),
    .fault_cause_o(fault_cause_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   {31'd0, bus.mem_req_o},    32'd0);
    check({tag, ".addr"},  bus.mem_addr_o,            32'h0);
    check({tag, ".inst"},  bus.inst_o,                32'h0);
    check({tag, ".pc"},    bus.inst_pc_o,             32'h0);
    check({tag, ".valid"}, {31'd0, bus.inst_valid_o}, 32'd0);
    check({tag, ".fault"}, {31'd0, fault_o},          32'd0);
    check({tag, ".cause"}, {30'd0, fault_cause_o},    32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_i          = 1'b1;
    redirect_i       = 1'b0;
    redirect_addr_i  = '0;
    bus.mem_ack_i    = 1'b0;
    bus.mem_data_i   = '0;
    bus.inst_ready_i = 1'b0;

    // Reset state
    #2;
    check_reset_outputs("rst");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Zero-wait fetch of 0x00100093 at PC 0
    step();
    check("lo0.req",  {31'd0, bus.mem_req_o}, 32'd1);
    check("lo0.addr", bus.mem_addr_o, 32'h0);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 16'h0093;
    step();
    check("hi0.addr",  bus.mem_addr_o, 32'h2);
    check("hi0.valid", {31'd0, bus.inst_valid_o}, 32'd0);
    bus.mem_data_i = 16'h0010;
    step();
    check("i0.valid", {31'd0, bus.inst_valid_o}, 32'd1);
    check("i0.inst",  bus.inst_o, 32'h0010_0093);
    check("i0.pc",    bus.inst_pc_o, 32'h0);
    bus.mem_ack_i  = 1'b0;

    // Stall in HOLD with stray acks, then accept
    for (int unsigned i = 0; i < 5; i++) begin
      bus.mem_ack_i  = (i % 2) == 0;
      bus.mem_data_i = 16'hFFFF;
      step();
      check("hold.valid", {31'd0, bus.inst_valid_o}, 32'd1);
      check("hold.inst",  bus.inst_o, 32'h0010_0093);
      check("hold.req",   {31'd0, bus.mem_req_o}, 32'd0);
    end
    bus.mem_ack_i    = 1'b0;
    bus.inst_ready_i = 1'b1;
    step();
    bus.inst_ready_i = 1'b0;
    check("acc.valid", {31'd0, bus.inst_valid_o}, 32'd0);
    check("acc.addr",  bus.mem_addr_o, 32'h4);
    check("acc.req",   {31'd0, bus.mem_req_o}, 32'd1);

    // Three wait cycles per halfword
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("wlo.addr", bus.mem_addr_o, 32'h4);
      check("wlo.req",  {31'd0, bus.mem_req_o}, 32'd1);
    end
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 16'h0513;
    step();
    bus.mem_ack_i  = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      check("whi.addr", bus.mem_addr_o, 32'h6);
      check("whi.req",  {31'd0, bus.mem_req_o}, 32'd1);
      step();
    end
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 16'h00A0;
    step();
    bus.mem_ack_i  = 1'b0;
    check("i1.inst",  bus.inst_o, 32'h00A0_0513);
    check("i1.pc",    bus.inst_pc_o, 32'h4);
    check("i1.valid", {31'd0, bus.inst_valid_o}, 32'd1);
    bus.inst_ready_i = 1'b1;
    step();
    bus.inst_ready_i = 1'b0;
    check("i2.addr", bus.mem_addr_o, 32'h8);

    // Redirect in the same cycle as the HI ack
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 16'h0013;
    step();
    check("i2hi.addr", bus.mem_addr_o, 32'hA);
    bus.mem_data_i  = 16'hDEAD;
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0100;
    step();
    redirect_i     = 1'b0;
    bus.mem_data_i = 16'h1111;
    check("rd.req",   {31'd0, bus.mem_req_o}, 32'd0);
    check("rd.valid", {31'd0, bus.inst_valid_o}, 32'd0);
    check("rd.inst",  bus.inst_o, 32'h00A0_0013);
    step();
    check("rd1.req",   {31'd0, bus.mem_req_o}, 32'd1);
    check("rd1.addr",  bus.mem_addr_o, 32'h100);
    check("rd1.fault", {31'd0, fault_o}, 32'd0);
    bus.mem_data_i = 16'h0093;
    step();
    check("rd2.addr", bus.mem_addr_o, 32'h102);
    bus.mem_data_i = 16'h0020;
    step();
    bus.mem_ack_i  = 1'b0;
    check("i3.inst", bus.inst_o, 32'h0020_0093);
    check("i3.pc",   bus.inst_pc_o, 32'h100);

    // Misaligned redirect, then recovery
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0102;
    step();
    redirect_i = 1'b0;
    check("mis.fault", {31'd0, fault_o}, 32'd1);
    check("mis.cause", {30'd0, fault_cause_o}, 32'd1);
    check("mis.valid", {31'd0, bus.inst_valid_o}, 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      check("mis.req", {31'd0, bus.mem_req_o}, 32'd0);
      step();
    end
    check("mis.hold", {31'd0, fault_o}, 32'd1);
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0200;
    step();
    redirect_i = 1'b0;
    check("rec.fault", {31'd0, fault_o}, 32'd0);
    check("rec.cause", {30'd0, fault_cause_o}, 32'd0);
    check("rec.req0",  {31'd0, bus.mem_req_o}, 32'd0);
    step();
    check("rec.req1", {31'd0, bus.mem_req_o}, 32'd1);
    check("rec.addr", bus.mem_addr_o, 32'h200);

    // Compressed encoding faults
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 16'h4501;
    step();
    bus.mem_ack_i = 1'b0;
    check("enc.fault", {31'd0, fault_o}, 32'd1);
    check("enc.cause", {30'd0, fault_cause_o}, 32'd2);
    check("enc.valid", {31'd0, bus.inst_valid_o}, 32'd0);
    check("enc.req",   {31'd0, bus.mem_req_o}, 32'd0);
    step();
    check("enc.hold", {30'd0, fault_cause_o}, 32'd2);

    // Asynchronous reset in the middle of HI
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0300;
    step();
    redirect_i = 1'b0;
    step();
    check("f4.addr", bus.mem_addr_o, 32'h300);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 16'h0093;
    step();
    check("f4hi.addr", bus.mem_addr_o, 32'h302);
    check("f4hi.req",  {31'd0, bus.mem_req_o}, 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_outputs("arst");
    bus.mem_ack_i = 1'b0;
    step();
    reset_i = 1'b0;
    step();
    check("post.req",  {31'd0, bus.mem_req_o}, 32'd1);
    check("post.addr", bus.mem_addr_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
